// File: rtl/exec_cond_stage.sv
// Execute-stage condition evaluation, NZCV flag register and EX->MEM pipeline register.
// Condition decode always reads the flags as they stood before this cycle's update.
module exec_cond_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic             valid_e,
  input  logic [3:0]       cond_e,
  input  logic [1:0]       flag_write_e,
  input  logic             reg_write_e,
  input  logic             mem_write_e,
  input  logic             mem_to_reg_e,
  input  logic             branch_e,
  input  logic             pred_taken_e,
  input  logic [3:0]       wa_e,
  input  logic [WIDTH-1:0] write_data_e,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_co,
  input  logic             alu_ovf,
  output logic             carry_in,
  output logic [3:0]       flags,
  output logic             cond_ex_e,
  output logic             branch_taken_e,
  output logic             mispredict_e,
  output logic             valid_m,
  output logic             reg_write_m,
  output logic             mem_write_m,
  output logic             mem_to_reg_m,
  output logic [3:0]       wa_m,
  output logic [WIDTH-1:0] alu_result_m,
  output logic [WIDTH-1:0] write_data_m
);

  logic [3:0]       flags_q, flags_d;
  logic             valid_q, valid_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_write_q, mem_write_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic [3:0]       wa_q, wa_d;
  logic [WIDTH-1:0] alu_result_q, alu_result_d;
  logic [WIDTH-1:0] write_data_q, write_data_d;

  logic flag_n, flag_z, flag_c, flag_v;
  logic go;
  logic live;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  always_comb begin
    cond_ex_e = 1'b0;
    unique case (cond_e)
      4'b0000: cond_ex_e = flag_z;
      4'b0001: cond_ex_e = ~flag_z;
      4'b0010: cond_ex_e = flag_c;
      4'b0011: cond_ex_e = ~flag_c;
      4'b0100: cond_ex_e = flag_n;
      4'b0101: cond_ex_e = ~flag_n;
      4'b0110: cond_ex_e = flag_v;
      4'b0111: cond_ex_e = ~flag_v;
      4'b1000: cond_ex_e = flag_c & ~flag_z;
      4'b1001: cond_ex_e = ~flag_c | flag_z;
      4'b1010: cond_ex_e = (flag_n == flag_v);
      4'b1011: cond_ex_e = (flag_n != flag_v);
      4'b1100: cond_ex_e = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex_e = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex_e = 1'b1;
      default: cond_ex_e = 1'b0;
    endcase
  end

  assign branch_taken_e = valid_e & branch_e & cond_ex_e & ~flush_e;
  assign mispredict_e   = valid_e & branch_e & ~flush_e & (branch_taken_e != pred_taken_e);

  // go commits flag side effects; live gates the control bits entering MEM.
  assign go   = valid_e & cond_ex_e & ~flush_e & ~stall_e;
  assign live = valid_e & cond_ex_e;

  always_comb begin
    flags_d = flags_q;
    if (go && flag_write_e[1]) begin
      flags_d[3] = alu_n;
      flags_d[2] = alu_z;
    end
    if (go && flag_write_e[0]) begin
      flags_d[1] = alu_co;
      flags_d[0] = alu_ovf;
    end
  end

  // Pipeline control: flush beats stall; stall holds everything; otherwise advance.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    wa_d         = wa_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    if (flush_e) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      wa_d         = wa_e;
      alu_result_d = alu_out;
      write_data_d = write_data_e;
    end else if (!stall_e) begin
      valid_d      = valid_e;
      reg_write_d  = reg_write_e & live;
      mem_write_d  = mem_write_e & live;
      mem_to_reg_d = mem_to_reg_e & live;
      wa_d         = wa_e;
      alu_result_d = alu_out;
      write_data_d = write_data_e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q      <= '0;
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      wa_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
    end else begin
      flags_q      <= flags_d;
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      wa_q         <= wa_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
    end
  end

  assign flags        = flags_q;
  assign carry_in     = flags_q[1];
  assign valid_m      = valid_q;
  assign reg_write_m  = reg_write_q;
  assign mem_write_m  = mem_write_q;
  assign mem_to_reg_m = mem_to_reg_q;
  assign wa_m         = wa_q;
  assign alu_result_m = alu_result_q;
  assign write_data_m = write_data_q;

endmodule

// File: tb/tb_exec_cond_stage.sv
// Bench for exec_cond_stage: condition table sweep, directed pipeline sequences and
// randomized traffic checked against an instruction-level model of flags and the MEM slot.
module tb_exec_cond_stage;
  localparam int WIDTH = 32;

  logic             clk, rst_n;
  logic             stall_e, flush_e, valid_e;
  logic [3:0]       cond_e;
  logic [1:0]       flag_write_e;
  logic             reg_write_e, mem_write_e, mem_to_reg_e, branch_e, pred_taken_e;
  logic [3:0]       wa_e;
  logic [WIDTH-1:0] write_data_e, alu_out;
  logic             alu_n, alu_z, alu_co, alu_ovf;
  logic             carry_in;
  logic [3:0]       flags;
  logic             cond_ex_e, branch_taken_e, mispredict_e;
  logic             valid_m, reg_write_m, mem_write_m, mem_to_reg_m;
  logic [3:0]       wa_m;
  logic [WIDTH-1:0] alu_result_m, write_data_m;

  exec_cond_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e), .valid_e(valid_e),
    .cond_e(cond_e), .flag_write_e(flag_write_e), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .mem_to_reg_e(mem_to_reg_e), .branch_e(branch_e),
    .pred_taken_e(pred_taken_e), .wa_e(wa_e), .write_data_e(write_data_e),
    .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_co(alu_co), .alu_ovf(alu_ovf),
    .carry_in(carry_in), .flags(flags), .cond_ex_e(cond_ex_e),
    .branch_taken_e(branch_taken_e), .mispredict_e(mispredict_e), .valid_m(valid_m),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .mem_to_reg_m(mem_to_reg_m),
    .wa_m(wa_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] flg;
    logic [3:0] cond;
    logic       exp;
  } cond_vec_t;
  cond_vec_t vec [256];

  // model state: architectural flags and the instruction sitting in MEM
  logic [3:0]       m_flags;
  logic             m_valid, m_rw, m_mw, m_mtr, m_data_known;
  logic [3:0]       m_wa;
  logic [WIDTH-1:0] m_res, m_wd;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Condition meaning from the architectural names.
  function automatic logic cond_ref(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v, ge;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    ge = (n == v);
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return ge;
      4'd11: return !ge;
      4'd12: return !z && ge;
      4'd13: return !(!z && ge);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_idle();
    stall_e = 0; flush_e = 0; valid_e = 0; cond_e = 4'he; flag_write_e = 2'b00;
    reg_write_e = 0; mem_write_e = 0; mem_to_reg_e = 0; branch_e = 0; pred_taken_e = 0;
    wa_e = 0; write_data_e = 0; alu_out = 0; alu_n = 0; alu_z = 0; alu_co = 0; alu_ovf = 0;
  endtask

  task automatic model_reset();
    m_flags = 0; m_valid = 0; m_rw = 0; m_mw = 0; m_mtr = 0;
    m_wa = 0; m_res = 0; m_wd = 0; m_data_known = 1;
  endtask

  // Inputs are already driven (at a negedge); check comb outputs, clock once, check state.
  task automatic step();
    logic ok, taken, mis;
    #1;
    ok    = cond_ref(m_flags, cond_e);
    taken = valid_e && branch_e && ok && !flush_e;
    mis   = valid_e && branch_e && !flush_e && (taken != pred_taken_e);
    check("cond_ex_e", cond_ex_e, ok);
    check("branch_taken_e", branch_taken_e, taken);
    check("mispredict_e", mispredict_e, mis);
    check("carry_in", carry_in, m_flags[1]);
    @(posedge clk);
    if (flush_e) begin
      m_valid = 0; m_rw = 0; m_mw = 0; m_mtr = 0; m_data_known = 0;
    end else if (!stall_e) begin
      if (valid_e && ok) begin
        if (flag_write_e[1]) begin m_flags[3] = alu_n;  m_flags[2] = alu_z;   end
        if (flag_write_e[0]) begin m_flags[1] = alu_co; m_flags[0] = alu_ovf; end
      end
      m_valid = valid_e;
      m_rw  = reg_write_e  && valid_e && ok;
      m_mw  = mem_write_e  && valid_e && ok;
      m_mtr = mem_to_reg_e && valid_e && ok;
      m_wa = wa_e; m_res = alu_out; m_wd = write_data_e; m_data_known = 1;
    end
    @(negedge clk);
    check("flags", flags, m_flags);
    check("valid_m", valid_m, m_valid);
    check("reg_write_m", reg_write_m, m_rw);
    check("mem_write_m", mem_write_m, m_mw);
    check("mem_to_reg_m", mem_to_reg_m, m_mtr);
    if (m_data_known) begin
      check("wa_m", wa_m, m_wa);
      check("alu_result_m", alu_result_m, m_res);
      check("write_data_m", write_data_m, m_wd);
    end
  endtask

  task automatic load_flags(input logic [3:0] f);
    set_idle();
    valid_e = 1; cond_e = 4'he; flag_write_e = 2'b11;
    {alu_n, alu_z, alu_co, alu_ovf} = f;
    step();
  endtask

  task automatic randomize_inputs();
    valid_e      = ($urandom_range(0, 3) != 0);
    cond_e       = 4'($urandom_range(0, 15));
    flag_write_e = 2'($urandom_range(0, 3));
    reg_write_e  = 1'($urandom_range(0, 1));
    mem_write_e  = 1'($urandom_range(0, 1));
    mem_to_reg_e = 1'($urandom_range(0, 1));
    branch_e     = 1'($urandom_range(0, 1));
    pred_taken_e = 1'($urandom_range(0, 1));
    wa_e         = 4'($urandom_range(0, 15));
    write_data_e = $urandom;
    alu_out      = $urandom;
    {alu_n, alu_z, alu_co, alu_ovf} = 4'($urandom_range(0, 15));
  endtask

  initial begin
    logic [3:0]       hold_flags;
    logic [WIDTH-1:0] hold_res;
    logic             hold_valid, hold_rw;

    for (int f = 0; f < 16; f++)
      for (int c = 0; c < 16; c++)
        vec[f*16+c] = '{flg: 4'(f), cond: 4'(c), exp: cond_ref(4'(f), 4'(c))};

    set_idle();
    model_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("reset flags", flags, 4'b0000);
    check("reset carry_in", carry_in, 1'b0);
    check("reset valid_m", valid_m, 1'b0);

    // SUBS sets Z and C, then BEQ sees them with no bubble
    set_idle();
    valid_e = 1; cond_e = 4'he; flag_write_e = 2'b11; alu_z = 1; alu_co = 1; reg_write_e = 1;
    step();
    check("subs flags", flags, 4'b0110);
    set_idle();
    valid_e = 1; cond_e = 4'h0; branch_e = 1; pred_taken_e = 0;
    #1;
    check("beq taken", branch_taken_e, 1'b1);
    check("beq mispredict", mispredict_e, 1'b1);
    step();

    // failed condition: flag-setter with EQ while Z=0 is a NOP in MEM
    load_flags(4'b0000);
    set_idle();
    valid_e = 1; cond_e = 4'h0; reg_write_e = 1; flag_write_e = 2'b11; alu_z = 1; alu_n = 1;
    step();
    check("failed cond reg_write_m", reg_write_m, 1'b0);
    check("failed cond valid_m", valid_m, 1'b1);
    check("failed cond flags", flags, 4'b0000);

    // carry feedback
    set_idle();
    valid_e = 1; flag_write_e = 2'b01; alu_co = 1;
    step();
    check("adds carry 1", carry_in, 1'b1);
    alu_co = 0;
    step();
    check("adds carry 0", carry_in, 1'b0);

    // stall for 3 cycles with live inputs, then flush+stall
    load_flags(4'b1010);
    set_idle();
    valid_e = 1; reg_write_e = 1; alu_out = 32'h1234_5678;
    step();
    hold_flags = flags; hold_res = alu_result_m; hold_valid = valid_m; hold_rw = reg_write_m;
    check("pre-stall flags", hold_flags, 4'b1010);
    check("pre-stall result", hold_res, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      valid_e = 1; cond_e = 4'he; flag_write_e = 2'b11; stall_e = 1; flush_e = 0;
      step();
      check("stall flags", flags, hold_flags);
      check("stall alu_result_m", alu_result_m, hold_res);
      check("stall valid_m", valid_m, hold_valid);
      check("stall reg_write_m", reg_write_m, hold_rw);
    end
    stall_e = 1; flush_e = 1;
    step();
    check("flush+stall valid_m", valid_m, 1'b0);
    check("flush+stall flags", flags, hold_flags);

    // exhaustive condition table
    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      set_idle();
      for (int c = 0; c < 16; c++) begin
        cond_e = vec[f*16+c].cond;
        #1;
        check($sformatf("cond table f=%0h c=%0h", vec[f*16+c].flg, vec[f*16+c].cond),
              cond_ex_e, vec[f*16+c].exp);
      end
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      stall_e = ($urandom_range(0, 4) == 0);
      flush_e = ($urandom_range(0, 7) == 0);
      step();
    end

    // async reset mid-cycle
    load_flags(4'b1111);
    set_idle();
    valid_e = 1; reg_write_e = 1;
    step();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check("async reset flags", flags, 4'b0000);
    check("async reset valid_m", valid_m, 1'b0);
    check("async reset reg_write_m", reg_write_m, 1'b0);
    @(negedge clk);
    rst_n = 1;
    set_idle();
    step();
    check("post reset carry_in", carry_in, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule
